// File: rtl/rca_seq_pkg.sv
// ============================================================================
//  Module   : rca_seq_pkg
//  Purpose  : Shared state encoding, slice width and sizing helpers for the
//             serial ripple-carry adder sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rca_seq_pkg;

  // Sequencer phases: waiting for operands, slicing, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rca_state_e;

  // Width of the ripple-carry slice processed each cycle.
  localparam int unsigned SLICE_W = 4;

  // Number of slice cycles needed to cover an operand of the given width.
  function automatic int unsigned nslice_of(input int unsigned width);
    return width / SLICE_W;
  endfunction

  // Counter width able to index every slice; never narrower than one bit.
  function automatic int unsigned cnt_width_of(input int unsigned nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rca_seq_ctrl_rca.sv
// ============================================================================
//  Module   : rca
//  Purpose  : 4-bit ripple-carry adder slice, one full adder per bit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  // Chain of full adders; each bit's carry feeds the next.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
// ============================================================================
//  Module   : rca_seq_ctrl
//  Purpose  : Serial WIDTH-bit adder: one 4-bit ripple-carry slice per cycle,
//             carry held in a register between slices, valid/ready on both
//             sides.
//  Options  : RCA_SEQ_CTRL_SUB_EN adds a 'sub' input; when set at accept,
//             b is inverted and the initial carry forced to 1 (sum = a - b,
//             cout = 1 means no borrow).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SEQ_CTRL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = nslice_of(WIDTH);
  localparam int unsigned CNT_W  = cnt_width_of(NSLICE);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  // Reject widths the slicing cannot cover exactly.
  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] result_shift;
  logic [WIDTH-1:0] b_capture;
  logic             carry_capture;

  // Single shared slice; operands are consumed from the low nibble upward.
  rca u_slice (
    .a    (op_a_q[3:0]),
    .b    (op_b_q[3:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top so the LSB nibble lands at bit 0 last.
  if (WIDTH == SLICE_W) begin : g_res_single
    assign result_shift = slice_sum;
  end else begin : g_res_multi
    assign result_shift = {slice_sum, result_q[WIDTH-1:SLICE_W]};
  end

`ifdef RCA_SEQ_CTRL_SUB_EN
  // Subtraction is two's complement: invert b and inject a carry of 1.
  assign b_capture     = sub ? ~b : b;
  assign carry_capture = sub ? 1'b1 : cin;
`else
  assign b_capture     = b;
  assign carry_capture = cin;
`endif

  // Next-state and datapath update for the three sequencer phases.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = b_capture;
          carry_d = carry_capture;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        op_a_d   = op_a_q >> SLICE_W;
        op_b_d   = op_b_q >> SLICE_W;
        result_d = result_shift;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = result_q;
  assign cout      = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
// ============================================================================
//  Module   : tb_rca_seq_ctrl
//  Purpose  : Self-checking bench for rca_seq_ctrl (WIDTH=16): directed cases,
//             backpressure, mid-run operand change, mid-run reset and a
//             randomized run against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rca_seq_ctrl;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_SEQ_CTRL_SUB_EN
    .sub       (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands as seen at accept.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    return r;
  endfunction

  // One full transaction with latency, hold and handshake checks.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic xs, input int hold, input bit change_mid, input string tag);
    logic [W:0] exp;
    int guard;
`ifdef RCA_SEQ_CTRL_SUB_EN
    exp = model(xa, xb, xc, xs);
`else
    exp = model(xa, xb, xc, 1'b0);
`endif
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk({tag, "_ready_wait"}, 32'(guard < 20), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; cin = xc; sub_in = xs;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom; sub_in = $urandom;
    for (int i = 0; i < NS; i++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      if (change_mid && i == 1) a = '0;
      step();
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(exp[W]));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      step();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_sum"}, 32'({cout, sum}), 32'(exp));
      chk({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_release_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_in = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'({cout, sum}), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    do_op(16'h1234, 16'h0FED, 1'b0, 1'b0, 0, 1'b0, "basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "wrap");
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0, "ripple");
    do_op(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, 5, 1'b0, "backpressure");
    do_op(16'h8001, 16'h7FFF, 1'b0, 1'b0, 0, 1'b1, "midchange");
    do_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1, 1'b0, "b2b");
`ifdef RCA_SEQ_CTRL_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, "sub_borrow");
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, "sub_noborrow");
`endif

    // Abort mid-run: outputs clear without waiting for a clock edge.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1; sub_in = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'({cout, sum}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NS + 2; i++) begin
      step();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // Randomized operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef RCA_SEQ_CTRL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
